ej32_st_ser: RTL and testbench

EJ32_ST_SER -- requirements
Module: ej32_st_ser

---
 rtl/ej32_st_ser_if.sv | 39 +++
 rtl/ej32_st_ser.sv | 169 ++++++++++++++++
 tb/tb_ej32_st_ser.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ej32_st_ser_if.sv
`default_nettype none
// ============================================================================
// Module      : ej32_st_ser_if
// Description : Bundle of the store-request side and the byte-wide memory
//               write side of the ej32 store serializer.
//               slave  : serializer view (request in, byte strobes out)
//               master : requester/memory view (drives req/sz/addr/wdata and
//                        mem_rdy, observes strobes and status)
// Ports       : req, sz[1:0], addr[ASZ-1:0], wdata[DSZ-1:0], mem_rdy,
//               mem_we, mem_a[ASZ-1:0], mem_d[7:0], busy, done, err
// Revision    : 1.0 - initial release
// ============================================================================
interface ej32_st_ser_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 32
);
    logic           req;
    logic [1:0]     sz;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] wdata;
    logic           mem_rdy;
    logic           mem_we;
    logic [ASZ-1:0] mem_a;
    logic [7:0]     mem_d;
    logic           busy;
    logic           done;
    logic           err;

    modport slave (
        input  req, sz, addr, wdata, mem_rdy,
        output mem_we, mem_a, mem_d, busy, done, err
    );

    modport master (
        output req, sz, addr, wdata, mem_rdy,
        input  mem_we, mem_a, mem_d, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/ej32_st_ser.sv
`default_nettype none
// ============================================================================
// Module      : ej32_st_ser
// Description : Serializes a byte/halfword/word store into big-endian byte
//               writes (MSB first) on a byte-wide memory port with a ready
//               handshake. Illegal size completes immediately with err.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - ej32_st_ser_if.slave (request in, byte strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
module ej32_st_ser #(
    parameter int ASZ = 17,
    parameter int DSZ = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ej32_st_ser_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q,  state_d;
    logic [ASZ-1:0] addr_q,   addr_d;
    logic [DSZ-1:0] wdata_q,  wdata_d;
    logic [2:0]     n_q,      n_d;
    logic [1:0]     idx_q,    idx_d;
    logic           mem_we_q, mem_we_d;
    logic [ASZ-1:0] mem_a_q,  mem_a_d;
    logic [7:0]     mem_d_q,  mem_d_d;
    logic           busy_q,   busy_d;
    logic           done_q,   done_d;
    logic           err_q,    err_d;
    logic [1:0]     idx_nx;

    // Byte count for a legal size code; 00 is filtered out before use.
    function automatic logic [2:0] size_to_n(input logic [1:0] s);
        case (s)
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte (n-1-idx) of the store value: big-endian, most significant first.
    function automatic logic [7:0] pick_byte(input logic [DSZ-1:0] d,
                                             input logic [2:0]     n,
                                             input logic [1:0]     idx);
        logic [2:0]     k;
        logic [DSZ-1:0] s;
        k = n - 3'd1 - {1'b0, idx};
        s = d >> {k, 3'b000};
        return s[7:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        n_d      = n_q;
        idx_d    = idx_q;
        mem_we_d = mem_we_q;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        idx_nx   = idx_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                mem_we_d = 1'b0;
                mem_a_d  = '0;
                mem_d_d  = '0;
                if (bus.req) begin
                    busy_d = 1'b1;
                    if (bus.sz != 2'b00) begin
                        // First byte is presented directly from the inputs so
                        // it appears on the bus in the cycle after acceptance.
                        state_d  = S_WRITE;
                        addr_d   = bus.addr;
                        wdata_d  = bus.wdata;
                        n_d      = size_to_n(bus.sz);
                        idx_d    = 2'd0;
                        mem_we_d = 1'b1;
                        mem_a_d  = bus.addr;
                        mem_d_d  = pick_byte(bus.wdata, size_to_n(bus.sz), 2'd0);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (bus.mem_rdy) begin
                    if ({1'b0, idx_q} == (n_q - 3'd1)) begin
                        state_d  = S_DONE;
                        mem_we_d = 1'b0;
                        mem_a_d  = '0;
                        mem_d_d  = '0;
                        done_d   = 1'b1;
                    end else begin
                        // Address adds wrap naturally at ASZ bits.
                        idx_d   = idx_nx;
                        mem_a_d = addr_q + ASZ'(idx_nx);
                        mem_d_d = pick_byte(wdata_q, n_q, idx_nx);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                mem_we_d = 1'b0;
                mem_a_d  = '0;
                mem_d_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_d_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.mem_we = mem_we_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_d  = mem_d_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ej32_st_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ej32_st_ser
// Description : Self-checking bench for ej32_st_ser. A reference model builds
//               the expected (address, byte) list of each store from the
//               size/address/value with plain arithmetic; the bench then
//               walks the memory handshake and compares every cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ej32_st_ser;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ej32_st_ser_if #(.ASZ(17), .DSZ(32)) bus ();

    ej32_st_ser #(.ASZ(17), .DSZ(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed status word: {busy, mem_we, mem_a, mem_d, done, err}.
    function automatic logic [28:0] obs();
        return {bus.busy, bus.mem_we, bus.mem_a, bus.mem_d, bus.done, bus.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: random ready; 2: first byte stalled twice.
    task automatic next_rdy(input int mode, inout int stall);
        if (mode == 1)
            bus.mem_rdy = ($urandom_range(0, 3) != 0);
        else if (mode == 2 && stall > 0) begin
            bus.mem_rdy = 1'b0;
            stall--;
        end else
            bus.mem_rdy = 1'b1;
    endtask

    // One complete store starting from IDLE, checked cycle by cycle.
    task automatic run_store(input string name, input logic [1:0] s,
                             input logic [16:0] a, input logic [31:0] d,
                             input int mode);
        logic [16:0] qa[$];
        logic [7:0]  qd[$];
        int          n, k, cyc, stall;
        logic        exp_err;
        logic [28:0] want;
        n       = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : (s == 2'b11) ? 4 : 0;
        exp_err = (s == 2'b00);
        for (int i = 0; i < n; i++) begin
            qa.push_back(17'(a + 17'(i)));
            qd.push_back(8'(d >> (8 * (n - 1 - i))));
        end
        stall = (mode == 2) ? 2 : 0;
        bus.req = 1'b1; bus.sz = s; bus.addr = a; bus.wdata = d;
        tick();
        // Scramble inputs after acceptance; the latched copy must hold.
        bus.req = 1'b0; bus.sz = 2'($urandom);
        bus.addr = 17'($urandom); bus.wdata = $urandom;
        k = 0; cyc = 1;
        while (k < n && cyc < 100) begin
            want = {1'b1, 1'b1, qa[k], qd[k], 1'b0, 1'b0};
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL %s byte%0d cyc%0d: got %h want %h", name, k, cyc, obs(), want);
            end
            next_rdy(mode, stall);
            if (bus.mem_rdy) k++;
            bus.req = ($urandom_range(0, 2) == 0);
            bus.sz  = 2'($urandom);
            tick();
            cyc++;
        end
        if (k < n) begin
            total++; bad++;
            $display("FAIL %s timeout: got %0d bytes want %0d", name, k, n);
        end
        want = {1'b1, 1'b0, 17'h0, 8'h0, 1'b1, exp_err};
        total++;
        if (obs() !== want) begin
            bad++;
            $display("FAIL %s done cyc%0d: got %h want %h", name, cyc, obs(), want);
        end
        // A request during the DONE cycle must be dropped.
        bus.req = $urandom_range(0, 1) != 0;
        tick();
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL %s idle: got %h want %h", name, obs(), 29'h0);
        end
        bus.req = 1'b0;
        tick();
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL %s no_queue: got %h want %h", name, obs(), 29'h0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 1'b1; bus.sz = 2'b11;
        bus.addr = 17'h00123; bus.wdata = 32'hFFFFFFFF; bus.mem_rdy = 1'b1;
        tick(); tick();
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs(), 29'h0);
        end
        rst = 1'b0; bus.req = 1'b0;
        tick();
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL reset_req_dropped: got %h want %h", obs(), 29'h0);
        end
    endtask

    task automatic test_directed();
        run_store("word",       2'b11, 17'h00100, 32'h11223344, 0);
        run_store("half_stall", 2'b10, 17'h00200, 32'hDEADBEEF, 2);
        run_store("byte_top",   2'b01, 17'h1FFFF, 32'h000000A5, 0);
        run_store("word_wrap",  2'b11, 17'h1FFFF, 32'hA1B2C3D4, 0);
        run_store("illegal",    2'b00, 17'h00040, 32'h12345678, 0);
    endtask

    task automatic test_abort();
        logic [28:0] want;
        bus.req = 1'b1; bus.sz = 2'b11; bus.addr = 17'h00300;
        bus.wdata = 32'hCAFEF00D; bus.mem_rdy = 1'b1;
        tick();
        bus.req = 1'b0;
        want = {1'b1, 1'b1, 17'h00300, 8'hCA, 1'b0, 1'b0};
        total++;
        if (obs() !== want) begin
            bad++;
            $display("FAIL abort_b0: got %h want %h", obs(), want);
        end
        tick();
        want = {1'b1, 1'b1, 17'h00301, 8'hFE, 1'b0, 1'b0};
        total++;
        if (obs() !== want) begin
            bad++;
            $display("FAIL abort_b1: got %h want %h", obs(), want);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL abort_rst: got %h want %h", obs(), 29'h0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs() !== 29'h0) begin
                bad++;
                $display("FAIL abort_quiet%0d: got %h want %h", i, obs(), 29'h0);
            end
        end
        run_store("after_abort", 2'b10, 17'h00310, 32'h00004321, 1);
    endtask

    task automatic test_back_to_back();
        logic [28:0] want [6];
        want[0] = {1'b1, 1'b1, 17'h00010, 8'h5A, 1'b0, 1'b0};
        want[1] = {1'b1, 1'b0, 17'h00000, 8'h00, 1'b1, 1'b0};
        want[2] = 29'h0;
        want[3] = {1'b1, 1'b1, 17'h00020, 8'hC3, 1'b0, 1'b0};
        want[4] = {1'b1, 1'b1, 17'h00021, 8'h3C, 1'b0, 1'b0};
        want[5] = {1'b1, 1'b0, 17'h00000, 8'h00, 1'b1, 1'b0};
        bus.req = 1'b1; bus.sz = 2'b01; bus.addr = 17'h00010;
        bus.wdata = 32'h0000005A; bus.mem_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 1) begin
                bus.sz = 2'b10; bus.addr = 17'h00020; bus.wdata = 32'h0000C33C;
            end
            if (c == 3) bus.req = 1'b0;
            total++;
            if (obs() !== want[c]) begin
                bad++;
                $display("FAIL b2b cyc%0d: got %h want %h", c + 1, obs(), want[c]);
            end
        end
        tick();
        total++;
        if (obs() !== 29'h0) begin
            bad++;
            $display("FAIL b2b idle: got %h want %h", obs(), 29'h0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++)
            run_store($sformatf("rand%0d", t), 2'($urandom), 17'($urandom),
                      $urandom, (t % 4 == 0) ? 0 : 1);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; bus.req = 1'b0; bus.sz = 2'b00;
        bus.addr = '0; bus.wdata = '0; bus.mem_rdy = 1'b0;
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
